// File: rtl/rob_fill_arbiter_if.sv
// rob_fill_arbiter_if
// Bundles the execute-side result requests and the ROB-side fill ports of
// rob_fill_arbiter.
//   req_valid/req_ready/req_idx/req_data/req_exc : one lane per result source
//   wp_valid/wp_idx/wp_data/wp_exc/wp_src        : one lane per ROB fill port
// Modports:
//   slave  - the arbiter (consumes requests, drives grants and fill ports)
//   master - the environment (drives requests, observes grants and fills)
interface rob_fill_arbiter_if #(
    parameter int NUM_REQ   = 6,
    parameter int NUM_WP    = 2,
    parameter int ROB_IDX_W = 5,
    parameter int DATA_W    = 32
) ();
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*ROB_IDX_W-1:0] req_idx;
    logic [NUM_REQ*DATA_W-1:0]    req_data;
    logic [NUM_REQ-1:0]           req_exc;

    logic [NUM_WP-1:0]            wp_valid;
    logic [NUM_WP*ROB_IDX_W-1:0]  wp_idx;
    logic [NUM_WP*DATA_W-1:0]     wp_data;
    logic [NUM_WP-1:0]            wp_exc;
    logic [NUM_WP*3-1:0]          wp_src;

    modport slave (
        input  req_valid, req_idx, req_data, req_exc,
        output req_ready,
        output wp_valid, wp_idx, wp_data, wp_exc, wp_src
    );

    modport master (
        output req_valid, req_idx, req_data, req_exc,
        input  req_ready,
        input  wp_valid, wp_idx, wp_data, wp_exc, wp_src
    );
endinterface

// File: rtl/rob_fill_arbiter.sv
// rob_fill_arbiter
// Shares the ROB completion-fill write ports between NUM_REQ execution-unit
// result sources. Each cycle up to NUM_WP valid sources are granted in
// round-robin order starting at rr_ptr and their results are registered into
// a single output stage that the ROB consumes unless it stalls.
// Ports:
//   clk       - clock, all state on posedge
//   rst_n     - asynchronous active-low reset
//   flush     - drops the output stage and restarts round-robin at source 0
//   rob_stall - ROB cannot accept fills; output stage and pointer hold
//   bus       - rob_fill_arbiter_if.slave: requests in, grants and fill ports out
module rob_fill_arbiter #(
    parameter int NUM_REQ   = 6,
    parameter int NUM_WP    = 2,
    parameter int ROB_IDX_W = 5,
    parameter int DATA_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                rob_stall,
    rob_fill_arbiter_if.slave   bus
);
    localparam int SRC_W = 3;
    localparam int CW    = SRC_W + 1;   // one extra bit so ptr+offset cannot overflow

    logic                  grant_en;
    logic [SRC_W-1:0]      rr_ptr_reg;
    logic [SRC_W-1:0]      rr_ptr_next;
    logic [SRC_W-1:0]      gnt_src [2];
    logic [1:0]            gnt_found;
    logic [SRC_W-1:0]      last_gnt;

    logic [NUM_WP-1:0]           wp_valid_reg;
    logic [NUM_WP*ROB_IDX_W-1:0] wp_idx_reg;
    logic [NUM_WP*DATA_W-1:0]    wp_data_reg;
    logic [NUM_WP-1:0]           wp_exc_reg;
    logic [NUM_WP*SRC_W-1:0]     wp_src_reg;

    assign grant_en = !rob_stall && !flush;

    // Round-robin scan: walk offsets 0..NUM_REQ-1 from rr_ptr, wrapping by
    // subtraction since NUM_REQ need not be a power of two. The first valid
    // source becomes grant 0, the next one grant 1.
    always_comb begin
        logic [CW-1:0] cand;
        gnt_found  = '0;
        gnt_src[0] = '0;
        gnt_src[1] = '0;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_reg} + CW'(i);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (bus.req_valid[cand[SRC_W-1:0]]) begin
                if (!gnt_found[0]) begin
                    gnt_found[0] = 1'b1;
                    gnt_src[0]   = cand[SRC_W-1:0];
                end else if (!gnt_found[1] && NUM_WP == 2) begin
                    gnt_found[1] = 1'b1;
                    gnt_src[1]   = cand[SRC_W-1:0];
                end
            end
        end
    end

    // Pointer moves just past the last grant of the cycle.
    always_comb begin
        last_gnt    = gnt_found[1] ? gnt_src[1] : gnt_src[0];
        rr_ptr_next = (last_gnt == SRC_W'(NUM_REQ - 1)) ? '0 : last_gnt + 1'b1;
    end

    // Ready is gated by rst_n so it is low for the whole time reset is held.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign bus.req_ready[gi] = rst_n && grant_en &&
                ((gnt_found[0] && gnt_src[0] == SRC_W'(gi)) ||
                 (gnt_found[1] && gnt_src[1] == SRC_W'(gi)));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_valid_reg <= '0;
            wp_idx_reg   <= '0;
            wp_data_reg  <= '0;
            wp_exc_reg   <= '0;
            wp_src_reg   <= '0;
            rr_ptr_reg   <= '0;
        end else if (flush) begin
            // Payload fields are don't-care after a flush and simply hold.
            wp_valid_reg <= '0;
            rr_ptr_reg   <= '0;
        end else if (!rob_stall) begin
            for (int p = 0; p < NUM_WP; p++) begin
                wp_valid_reg[p]                       <= gnt_found[p];
                wp_src_reg[p*SRC_W +: SRC_W]          <= gnt_src[p];
                wp_idx_reg[p*ROB_IDX_W +: ROB_IDX_W]  <= bus.req_idx[int'(gnt_src[p])*ROB_IDX_W +: ROB_IDX_W];
                wp_data_reg[p*DATA_W +: DATA_W]       <= bus.req_data[int'(gnt_src[p])*DATA_W +: DATA_W];
                wp_exc_reg[p]                         <= bus.req_exc[gnt_src[p]];
            end
            if (gnt_found[0]) begin
                rr_ptr_reg <= rr_ptr_next;
            end
        end
    end

    assign bus.wp_valid = wp_valid_reg;
    assign bus.wp_idx   = wp_idx_reg;
    assign bus.wp_data  = wp_data_reg;
    assign bus.wp_exc   = wp_exc_reg;
    assign bus.wp_src   = wp_src_reg;

endmodule

// File: tb/tb_rob_fill_arbiter.sv
// Scoreboard bench for rob_fill_arbiter. The driver issues one cycle of
// stimulus at a time, runs a round-robin reference model (ordered list of
// valid sources from the model pointer) and queues the expected grant vector
// and the expected output stage. An independent monitor pops and compares on
// each falling edge.
module tb_rob_fill_arbiter;
    localparam int N  = 6;
    localparam int W  = 2;
    localparam int IW = 5;
    localparam int DW = 32;

    typedef struct packed {
        logic [1:0]  v;
        logic [9:0]  idx;
        logic [63:0] data;
        logic [1:0]  exc;
        logic [5:0]  src;
    } wp_t;

    logic clk;
    logic rst_n;
    logic flush;
    logic rob_stall;

    rob_fill_arbiter_if #(.NUM_REQ(N), .NUM_WP(W), .ROB_IDX_W(IW), .DATA_W(DW)) bus ();

    rob_fill_arbiter #(.NUM_REQ(N), .NUM_WP(W), .ROB_IDX_W(IW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .rob_stall (rob_stall),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [N-1:0] exp_ready_q [$];
    wp_t          exp_wp_q [$];
    wp_t          pend;
    int           m_ptr;
    bit           mon_en;

    // Optional fixed payload for one source, used by directed cases.
    bit           fix_en;
    int           fix_src;
    logic [IW-1:0] fix_idx;
    logic [DW-1:0] fix_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One stimulus cycle: inputs change 1 time unit after the posedge.
    task automatic step(input logic [N-1:0] v, input logic fl, input logic st);
        logic [N*IW-1:0] idx;
        logic [N*DW-1:0] data;
        logic [N-1:0]    exc;
        logic [N-1:0]    rdy;
        int              g[$];
        int              base;
        @(posedge clk);
        #1;
        exp_wp_q.push_back(pend);
        base = $urandom_range(0, 31);
        for (int k = 0; k < N; k++) begin
            idx[k*IW +: IW]  = IW'((base + 5 * k) % 32);
            data[k*DW +: DW] = $urandom;
        end
        exc = N'($urandom);
        if (fix_en) begin
            idx[fix_src*IW +: IW]  = fix_idx;
            data[fix_src*DW +: DW] = fix_data;
        end
        for (int a = 0; a < N; a++)
            for (int b = a + 1; b < N; b++)
                if (v[a] && v[b] && idx[a*IW +: IW] == idx[b*IW +: IW])
                    $error("duplicate req_idx between sources %0d and %0d", a, b);
        bus.req_valid = v;
        bus.req_idx   = idx;
        bus.req_data  = data;
        bus.req_exc   = exc;
        flush         = fl;
        rob_stall     = st;
        // Reference: valid sources listed in round-robin order from the pointer.
        for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (v[k] && g.size() < W) g.push_back(k);
        end
        rdy = '0;
        if (!fl && !st)
            foreach (g[j]) rdy[g[j]] = 1'b1;
        exp_ready_q.push_back(rdy);
        if (fl) begin
            pend.v = '0;
            m_ptr  = 0;
        end else if (!st) begin
            pend.v = '0;
            foreach (g[j]) begin
                pend.v[j]          = 1'b1;
                pend.src[j*3 +: 3] = 3'(g[j]);
                pend.idx[j*IW +: IW]  = idx[g[j]*IW +: IW];
                pend.data[j*DW +: DW] = data[g[j]*DW +: DW];
                pend.exc[j]        = exc[g[j]];
            end
            if (g.size() > 0) m_ptr = (g[g.size() - 1] + 1) % N;
        end
    endtask

    // Monitor: one comparison set per falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_ready_q.size() > 0) begin
                logic [N-1:0] r;
                r = exp_ready_q.pop_front();
                chk("req_ready", 64'(bus.req_ready), 64'(r));
            end
            if (exp_wp_q.size() > 0) begin
                wp_t e;
                e = exp_wp_q.pop_front();
                chk("wp_valid", 64'(bus.wp_valid), 64'(e.v));
                for (int p = 0; p < W; p++) begin
                    if (e.v[p]) begin
                        chk($sformatf("wp_idx[%0d]", p),  64'(bus.wp_idx[p*IW +: IW]),  64'(e.idx[p*IW +: IW]));
                        chk($sformatf("wp_data[%0d]", p), 64'(bus.wp_data[p*DW +: DW]), 64'(e.data[p*DW +: DW]));
                        chk($sformatf("wp_exc[%0d]", p),  64'(bus.wp_exc[p]),           64'(e.exc[p]));
                        chk($sformatf("wp_src[%0d]", p),  64'(bus.wp_src[p*3 +: 3]),    64'(e.src[p*3 +: 3]));
                    end
                end
                if (bus.wp_valid != 0)
                    $display("fill v=%b src0=%0d src1=%0d idx=%h", bus.wp_valid,
                             bus.wp_src[2:0], bus.wp_src[5:3], bus.wp_idx);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    logic [N-1:0] pair_exp [4];

    initial begin
        pair_exp[0] = 6'b000011;
        pair_exp[1] = 6'b001100;
        pair_exp[2] = 6'b110000;
        pair_exp[3] = 6'b000011;
        mon_en        = 1'b0;
        fix_en        = 1'b0;
        fix_src       = 0;
        fix_idx       = '0;
        fix_data      = '0;
        pend          = '0;
        m_ptr         = 0;
        rst_n         = 1'b0;
        flush         = 1'b0;
        rob_stall     = 1'b0;
        bus.req_valid = '1;
        bus.req_idx   = '0;
        bus.req_data  = '0;
        bus.req_exc   = '0;

        // Reset state, with every source requesting.
        #12;
        chk("rst req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst wp_valid",  64'(bus.wp_valid),  64'd0);
        chk("rst wp_idx",    64'(bus.wp_idx),    64'd0);
        chk("rst wp_data",   64'(bus.wp_data),   64'd0);
        chk("rst wp_exc",    64'(bus.wp_exc),    64'd0);
        chk("rst wp_src",    64'(bus.wp_src),    64'd0);
        bus.req_valid = '0;
        #5;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single request from source 3.
        fix_en = 1'b1; fix_src = 3; fix_idx = 5'd7; fix_data = 32'hDEAD;
        step(6'b001000, 0, 0);
        fix_en = 1'b0;
        @(negedge clk); #1;
        chk("single ready", 64'(bus.req_ready), 64'b001000);
        step(6'b000000, 0, 0);
        @(negedge clk); #1;
        chk("single wp_valid", 64'(bus.wp_valid), 64'b01);
        chk("single wp_idx0",  64'(bus.wp_idx[4:0]), 64'd7);
        chk("single wp_data0", 64'(bus.wp_data[31:0]), 64'hDEAD);
        chk("single wp_src0",  64'(bus.wp_src[2:0]), 64'd3);

        // Flush to put the pointer at 0, then all six valid for 4 cycles.
        step(6'b000000, 1, 0);
        for (int c = 0; c < 4; c++) begin
            step(6'b111111, 0, 0);
            @(negedge clk); #1;
            chk($sformatf("pair%0d ready", c), 64'(bus.req_ready), 64'(pair_exp[c]));
        end

        // Stall for 3 cycles: no grants, output stage keeps the (0,1) pair.
        for (int c = 0; c < 3; c++) begin
            step(6'b111111, 0, 1);
            @(negedge clk); #1;
            chk("stall ready",    64'(bus.req_ready), 64'd0);
            chk("stall wp_valid", 64'(bus.wp_valid),  64'b11);
            chk("stall wp_src",   64'(bus.wp_src),    64'(6'b001_000));
        end
        step(6'b111111, 0, 0);
        @(negedge clk); #1;
        chk("post-stall ready", 64'(bus.req_ready), 64'b001100);

        // Flush with 4 sources valid and both ports occupied.
        step(6'b001111, 1, 0);
        @(negedge clk); #1;
        chk("flush ready",     64'(bus.req_ready), 64'd0);
        chk("flush wp_valid0", 64'(bus.wp_valid),  64'b11);
        step(6'b111111, 0, 0);
        @(negedge clk); #1;
        chk("post-flush wp_valid", 64'(bus.wp_valid), 64'd0);
        chk("post-flush ready",    64'(bus.req_ready), 64'b000011);

        // Wrap-around from pointer 5.
        step(6'b010000, 0, 0);
        step(6'b100001, 0, 0);
        @(negedge clk); #1;
        chk("wrap ready", 64'(bus.req_ready), 64'b100001);
        step(6'b010000, 0, 0);
        @(negedge clk); #1;
        chk("wrap wp_valid", 64'(bus.wp_valid), 64'b11);
        chk("wrap wp_src",   64'(bus.wp_src),   64'(6'b000_101));
        step(6'b000100, 0, 0);
        @(negedge clk); #1;
        chk("wrap2 ready", 64'(bus.req_ready), 64'b000100);
        step(6'b000000, 0, 0);
        @(negedge clk); #1;
        chk("wrap2 wp_valid", 64'(bus.wp_valid), 64'b01);
        chk("wrap2 wp_src0",  64'(bus.wp_src[2:0]), 64'd2);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            step(N'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 6) == 0);
        end

        // Asynchronous reset between clock edges while both ports are full.
        step(6'b111111, 0, 0);
        step(6'b111111, 0, 0);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("async wp_valid",  64'(bus.wp_valid),  64'd0);
        chk("async req_ready", 64'(bus.req_ready), 64'd0);
        chk("async wp_data",   64'(bus.wp_data),   64'd0);
        bus.req_valid = '0;
        exp_ready_q.delete();
        exp_wp_q.delete();
        pend  = '0;
        m_ptr = 0;
        #3;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step(6'b111111, 0, 0);
        @(negedge clk); #1;
        chk("post-reset ready", 64'(bus.req_ready), 64'b000011);
        for (int c = 0; c < 20; c++) begin
            step(N'($urandom), 0, $urandom_range(0, 4) == 0);
        end
        step(6'b000000, 0, 0);
        @(posedge clk); #1;
        @(negedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
